ps2_ctrl_fsm: RTL and testbench
===============================

# ps2_ctrl_fsm

Control unit for the PS/2 host controller. It sequences `ps2_dp` by driving its `ps2_pkg::ctrl_t` bundle from the datapath's `ps2_pkg::status_t` flags. It runs device-to-host reception, host-to-device transmission (request-to-send, bit shifting, acknowledge check) and all watchdog aborts. It also owns the open-drain PS/2 clock driver. The parent `ps2_if` instantiates it next to `ps2_dp`.

## Interface
- No parameters. All timing constants live in `ps2_dp`; this block only selects them via `tc_mux`.
- `clk` in 1: system clock, shared with `ps2_dp`.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: request to send the byte present on `ps2_dp.tx_data`.
- `tx_ready` out 1: transmit request accepted in this cycle when `tx_valid & tx_ready`.
- `tx_done` out 1: one-cycle pulse when a transmission ends (acknowledged, nacked or timed out).
- `tx_err` out 1: valid with `tx_done`; set on no-ack or watchdog timeout.
- `rx_valid` out 1: one-cycle pulse; `ps2_dp.rx_data` is valid in the same cycle.
- `rx_perr`, `rx_ferr`, `rx_toerr` out 1 each: valid with `rx_valid`; parity, framing and edge-watchdog errors.
- `busy` out 1: state is not IDLE.
- `ps2_clk_od` out 1: open-drain clock driver; 0 pulls low, 1 releases.
- `ctrl` out `ps2_pkg::ctrl_t`: datapath controls.
- `status` in `ps2_pkg::status_t`: datapath flags.

## Operation
- Reset and IDLE values:
  - Registered outputs: `ps2_clk_od`=1; `tx_done`, `tx_err`, `rx_valid` and all error flags = 0.
  - Combinational outputs in IDLE: `tx_ready`=1, `busy`=0.
  - `ctrl` in IDLE: `odreg_clk_en`=1 with `ps2_dat_mux`=00 (data line released); `tim_clear`=1; `bitcnt_clear`=1; every other enable 0.
- States: IDLE, RX_BIT, TX_INH, TX_RTS, TX_DLY, TX_WAIT.
- Bit counter: `bitcnt` increments on every counted negedge. Status flags reflect the value before the increment.
- Timers: `tim_clear` is asserted for exactly one cycle on entry to every timed state. `tim_clk_en`=1 in all non-IDLE states.
- IDLE:
  - `status.ps2_clk_negedge` → RX_BIT. This counts bit 0; `rx_ferr` is latched if `status.ps2_dat`=1.
  - Otherwise `tx_valid` → TX_INH. Load the shift register (`shreg_clk_en`=1, `shreg_shift_load_n`=0) and set `pbit_mux`=01.
  - `tx_ready` = IDLE & ~`ps2_clk_negedge`. Reception wins over a simultaneous transmit request.
- RX_BIT (`tc_mux`=10, 110 µs edge watchdog). On each negedge: `bitcnt_clk_en`=1 and the timer is cleared.
  - `dbits`: shift right (`shreg_clk_en`=1, `shift_load_n`=1) and `pbit_mux`=10.
  - `bitcnt_9`: latch `perr`.
  - `bitcnt_10`: latch `rx_ferr` (bad stop bit) and pulse `idreg_clk_en`. Assert `rx_valid` in the next cycle, then go to IDLE.
  - `tim_tc` before the stop bit: `rx_valid` with `rx_toerr`=1; `rx_data` is not updated; go to IDLE.
- TX_INH (`tc_mux`=01): `ps2_clk_od`=0 for 100 µs. On `tim_tc`, drive the data line low (`ps2_dat_mux`=01, `odreg_clk_en`=1) → TX_RTS.
- TX_RTS (`tc_mux`=11): clock released; the data line stays low as the start bit.
  - Negedge: increment `bitcnt` → TX_DLY.
  - `tim_tc` (15 ms): release data, `tx_done` with `tx_err`=1 → IDLE.
- TX_DLY (`tc_mux`=00, 15 µs). On `tim_tc`, with `odreg_clk_en`=1:
  - `dbits`: `ps2_dat_mux`=10, shift, `pbit_mux`=11.
  - `bitcnt_9`: `ps2_dat_mux`=11 (parity).
  - `bitcnt_10`: `ps2_dat_mux`=00 (stop bit = release).
  - Then → TX_WAIT.
- TX_WAIT (`tc_mux`=10):
  - Negedge with `bitcnt_10`: acknowledge sample. `tx_err` = `status.ps2_dat`; `tx_done` → IDLE.
  - Other negedge: increment → TX_DLY.
  - `tim_tc`: release, `tx_done` with `tx_err`=1 → IDLE.
- Reset mid-frame: immediate return to IDLE; the clock is released asynchronously. No `tx_done` or `rx_valid` is issued.

## Timing
- `ctrl` is combinational from state and `status`; `ps2_dp` registers act on the same edge.
- `rx_valid` and `tx_done` are registered: one cycle after the completing negedge or `tim_tc`.
- Timer resolution is one prescaler tick (5 µs at 50 MHz, `PSC`=249). Each delay is exact within +1 tick. `tim_tc` lasts one cycle.

## Structure
- Add to `ps2_pkg`:
  - `ps2_state_e`, 3-bit.
  - Mux encodings for `ps2_dat_mux`, `tc_mux` and `pbit_mux`.
  - `ps2_clk_od` if the package also carries the pad bundle.
- No sub-module. A single state register, Mealy `ctrl` decode and a registered flag block. `ps2_if` wires this block to `ps2_dp`.

## Test plan
- Device sends 0xA5 (odd parity 1, stop 1) → `rx_valid` with `rx_data`=0xA5 and all error flags 0.
- 0xA5 sent with parity 0 → `rx_valid`, `rx_perr`=1.
- Device stops the clock after 4 bits → `rx_toerr` 110–115 µs after the last negedge; `rx_data` unchanged.
- `tx_valid` with 0xFF → clock low for ≥100 µs; data bits 1×8, parity 1, release; device acks low → `tx_done`, `tx_err`=0.
- No device clock after RTS → `tx_done` with `tx_err`=1 at 15 ms (+5 µs); both lines released.
- `rst_n` asserted during TX_INH → `ps2_clk_od`=1 asynchronously, `tx_ready`=1 after release, no `tx_done`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 host controller: FSM state encoding, datapath
// mux selects and the ctrl/status bundles between ps2_ctrl_fsm and ps2_dp.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_BIT  = 3'd1,
        ST_TX_INH  = 3'd2,
        ST_TX_RTS  = 3'd3,
        ST_TX_DLY  = 3'd4,
        ST_TX_WAIT = 3'd5
    } ps2_state_e;

    // Source of the open-drain data line register
    localparam logic [1:0] DAT_RELEASE = 2'b00;  // idle / stop bit
    localparam logic [1:0] DAT_LOW     = 2'b01;  // request-to-send start bit
    localparam logic [1:0] DAT_SHREG   = 2'b10;  // current data bit (shreg LSB)
    localparam logic [1:0] DAT_PBIT    = 2'b11;  // accumulated odd parity

    // Timer terminal-count select
    localparam logic [1:0] TC_15US  = 2'b00;     // host data setup delay
    localparam logic [1:0] TC_100US = 2'b01;     // clock inhibit
    localparam logic [1:0] TC_110US = 2'b10;     // edge watchdog
    localparam logic [1:0] TC_15MS  = 2'b11;     // device response watchdog

    // Parity accumulator operation
    localparam logic [1:0] PBIT_HOLD = 2'b00;
    localparam logic [1:0] PBIT_INIT = 2'b01;    // preset for odd parity
    localparam logic [1:0] PBIT_RX   = 2'b10;    // fold in sampled line bit
    localparam logic [1:0] PBIT_TX   = 2'b11;    // fold in outgoing shreg bit

    typedef struct packed {
        logic       odreg_clk_en;
        logic [1:0] ps2_dat_mux;
        logic       shreg_clk_en;
        logic       shreg_shift_load_n;
        logic [1:0] pbit_mux;
        logic       bitcnt_clear;
        logic       bitcnt_clk_en;
        logic       tim_clear;
        logic       tim_clk_en;
        logic [1:0] tc_mux;
        logic       idreg_clk_en;
    } ctrl_t;

    typedef struct packed {
        logic ps2_clk_negedge;  // synchronised falling edge on the clock line
        logic ps2_dat;          // synchronised data line
        logic dbits;            // bit counter in 1..8
        logic bitcnt_9;
        logic bitcnt_10;
        logic perr;             // sampled parity bit disagrees with accumulator
        logic tim_tc;           // selected timer terminal count
    } status_t;

endpackage

// File: rtl/ps2_ctrl_fsm.sv
// PS/2 host control unit: sequences ps2_dp for device-to-host reception,
// host-to-device transmission and watchdog aborts, and owns the clock driver.
module ps2_ctrl_fsm
    import ps2_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    tx_valid,
    output logic    tx_ready,
    output logic    tx_done,
    output logic    tx_err,
    output logic    rx_valid,
    output logic    rx_perr,
    output logic    rx_ferr,
    output logic    rx_toerr,
    output logic    busy,
    output logic    ps2_clk_od,
    output ctrl_t   ctrl,
    input  status_t status
);

    ps2_state_e state_q, state_d;

    // Error accumulators live across the frame; outputs only show them with rx_valid
    logic perr_acc_q, perr_acc_d;
    logic ferr_acc_q, ferr_acc_d;
    logic rx_done_d, rx_toerr_d;
    logic tx_done_d, tx_err_d;

    logic rx_valid_q, rx_perr_q, rx_ferr_q, rx_toerr_q;
    logic tx_done_q, tx_err_q, ps2_clk_od_q;

    // Mealy decode of next state, datapath controls and completion events
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d                 = state_q;
        ctrl.odreg_clk_en       = 1'b0;
        ctrl.ps2_dat_mux        = DAT_RELEASE;
        ctrl.shreg_clk_en       = 1'b0;
        ctrl.shreg_shift_load_n = 1'b1;
        ctrl.pbit_mux           = PBIT_HOLD;
        ctrl.bitcnt_clear       = 1'b0;
        ctrl.bitcnt_clk_en      = 1'b0;
        ctrl.tim_clear          = 1'b0;
        ctrl.tim_clk_en         = (state_q != ST_IDLE);
        ctrl.tc_mux             = TC_15US;
        ctrl.idreg_clk_en       = 1'b0;
        tx_ready                = 1'b0;
        perr_acc_d              = perr_acc_q;
        ferr_acc_d              = ferr_acc_q;
        rx_done_d               = 1'b0;
        rx_toerr_d              = 1'b0;
        tx_done_d               = 1'b0;
        tx_err_d                = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ctrl.odreg_clk_en = 1'b1;
                ctrl.tim_clear    = 1'b1;
                ctrl.bitcnt_clear = 1'b1;
                // A device clock edge blocks a same-cycle transmit handshake
                tx_ready          = ~status.ps2_clk_negedge;
                if (status.ps2_clk_negedge) begin
                    // Start bit: counted here, must be sampled low
                    ctrl.bitcnt_clear  = 1'b0;
                    ctrl.bitcnt_clk_en = 1'b1;
                    perr_acc_d         = 1'b0;
                    ferr_acc_d         = status.ps2_dat;
                    state_d            = ST_RX_BIT;
                end else if (tx_valid) begin
                    ctrl.shreg_clk_en       = 1'b1;
                    ctrl.shreg_shift_load_n = 1'b0;
                    ctrl.pbit_mux           = PBIT_INIT;
                    state_d                 = ST_TX_INH;
                end
            end

            ST_RX_BIT: begin
                ctrl.tc_mux = TC_110US;
                if (status.ps2_clk_negedge) begin
                    ctrl.bitcnt_clk_en = 1'b1;
                    ctrl.tim_clear     = 1'b1;
                    if (status.dbits) begin
                        ctrl.shreg_clk_en = 1'b1;
                        ctrl.pbit_mux     = PBIT_RX;
                    end
                    if (status.bitcnt_9) begin
                        perr_acc_d = status.perr;
                    end
                    if (status.bitcnt_10) begin
                        ferr_acc_d        = ferr_acc_q | ~status.ps2_dat;
                        ctrl.idreg_clk_en = 1'b1;
                        rx_done_d         = 1'b1;
                        state_d           = ST_IDLE;
                    end
                end else if (status.tim_tc) begin
                    // Device stalled mid-frame: report without loading rx_data
                    rx_done_d  = 1'b1;
                    rx_toerr_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            ST_TX_INH: begin
                ctrl.tc_mux = TC_100US;
                if (status.tim_tc) begin
                    ctrl.odreg_clk_en = 1'b1;
                    ctrl.ps2_dat_mux  = DAT_LOW;
                    ctrl.tim_clear    = 1'b1;
                    state_d           = ST_TX_RTS;
                end
            end

            ST_TX_RTS: begin
                ctrl.tc_mux = TC_15MS;
                if (status.ps2_clk_negedge) begin
                    ctrl.bitcnt_clk_en = 1'b1;
                    ctrl.tim_clear     = 1'b1;
                    state_d            = ST_TX_DLY;
                end else if (status.tim_tc) begin
                    ctrl.odreg_clk_en = 1'b1;
                    tx_done_d         = 1'b1;
                    tx_err_d          = 1'b1;
                    state_d           = ST_IDLE;
                end
            end

            ST_TX_DLY: begin
                ctrl.tc_mux = TC_15US;
                if (status.tim_tc) begin
                    ctrl.odreg_clk_en = 1'b1;
                    ctrl.tim_clear    = 1'b1;
                    if (status.dbits) begin
                        ctrl.ps2_dat_mux  = DAT_SHREG;
                        ctrl.shreg_clk_en = 1'b1;
                        ctrl.pbit_mux     = PBIT_TX;
                    end else if (status.bitcnt_9) begin
                        ctrl.ps2_dat_mux = DAT_PBIT;
                    end else begin
                        ctrl.ps2_dat_mux = DAT_RELEASE;
                    end
                    state_d = ST_TX_WAIT;
                end
            end

            ST_TX_WAIT: begin
                ctrl.tc_mux = TC_110US;
                if (status.ps2_clk_negedge) begin
                    if (status.bitcnt_10) begin
                        // Acknowledge: device holds data low on this edge
                        tx_done_d = 1'b1;
                        tx_err_d  = status.ps2_dat;
                        state_d   = ST_IDLE;
                    end else begin
                        ctrl.bitcnt_clk_en = 1'b1;
                        ctrl.tim_clear     = 1'b1;
                        state_d            = ST_TX_DLY;
                    end
                end else if (status.tim_tc) begin
                    ctrl.odreg_clk_en = 1'b1;
                    tx_done_d         = 1'b1;
                    tx_err_d          = 1'b1;
                    state_d           = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register, error accumulators and registered handshake/pad outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_toerr_q   <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            ps2_clk_od_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            rx_valid_q   <= rx_done_d;
            rx_perr_q    <= rx_done_d & perr_acc_d;
            rx_ferr_q    <= rx_done_d & ferr_acc_d;
            rx_toerr_q   <= rx_toerr_d;
            tx_done_q    <= tx_done_d;
            tx_err_q     <= tx_done_d & tx_err_d;
            ps2_clk_od_q <= (state_d != ST_TX_INH);
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign rx_valid   = rx_valid_q;
    assign rx_perr    = rx_perr_q;
    assign rx_ferr    = rx_ferr_q;
    assign rx_toerr   = rx_toerr_q;
    assign tx_done    = tx_done_q;
    assign tx_err     = tx_err_q;
    assign ps2_clk_od = ps2_clk_od_q;

endmodule

// File: tb/tb_ps2_ctrl_fsm.sv
// Bench for ps2_ctrl_fsm: a small behavioural ps2_dp (scaled-down timers) and
// a PS/2 device drive the FSM; a scoreboard checks every rx_valid/tx_done.
module tb_ps2_ctrl_fsm;
    import ps2_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    tx_valid;
    logic    tx_ready, tx_done, tx_err;
    logic    rx_valid, rx_perr, rx_ferr, rx_toerr;
    logic    busy, ps2_clk_od;
    ctrl_t   ctrl;
    status_t status;

    always #5 clk = ~clk;

    ps2_ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .rx_valid   (rx_valid),
        .rx_perr    (rx_perr),
        .rx_ferr    (rx_ferr),
        .rx_toerr   (rx_toerr),
        .busy       (busy),
        .ps2_clk_od (ps2_clk_od),
        .ctrl       (ctrl),
        .status     (status)
    );

    // ---------------- counters and check ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- device side and pads ----------------
    logic       dev_clk, dev_dat;
    logic [7:0] tx_data;
    logic       odreg;
    logic       pad_clk, pad_dat;

    assign pad_clk = dev_clk & ps2_clk_od;
    assign pad_dat = dev_dat & odreg;

    // ---------------- behavioural datapath ----------------
    logic        clk_d1, clk_d2, dat_d1;
    logic [3:0]  bitcnt;
    logic [15:0] tim;
    logic [7:0]  shreg, idreg;
    logic        pbit;
    logic [1:0]  tc_sel_q;
    logic        tim_act_q;

    // Scaled timer limits in cycles: 15us->3, 100us->20, 110us->30, 15ms->200
    function automatic logic [15:0] lim(input logic [1:0] s);
        case (s)
            2'b00:   lim = 16'd3;
            2'b01:   lim = 16'd20;
            2'b10:   lim = 16'd30;
            default: lim = 16'd200;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_d1 <= 1'b1; clk_d2 <= 1'b1; dat_d1 <= 1'b1;
            bitcnt <= '0; tim <= '0; shreg <= '0; idreg <= '0;
            pbit <= 1'b1; odreg <= 1'b1; tc_sel_q <= '0; tim_act_q <= 1'b0;
        end else begin
            clk_d1    <= pad_clk;
            clk_d2    <= clk_d1;
            dat_d1    <= pad_dat;
            tc_sel_q  <= ctrl.tc_mux;
            tim_act_q <= ctrl.tim_clk_en;
            if (ctrl.bitcnt_clear)       bitcnt <= '0;
            else if (ctrl.bitcnt_clk_en) bitcnt <= bitcnt + 4'd1;
            if (ctrl.tim_clear)          tim <= '0;
            else if (ctrl.tim_clk_en)    tim <= tim + 16'd1;
            if (ctrl.shreg_clk_en) begin
                if (!ctrl.shreg_shift_load_n) shreg <= tx_data;
                else                          shreg <= {dat_d1, shreg[7:1]};
            end
            if (ctrl.pbit_mux == 2'b01)      pbit <= 1'b1;
            else if (ctrl.pbit_mux == 2'b10) pbit <= pbit ^ dat_d1;
            else if (ctrl.pbit_mux == 2'b11) pbit <= pbit ^ shreg[0];
            else if (ctrl.bitcnt_clear)      pbit <= 1'b1;
            if (ctrl.odreg_clk_en) begin
                case (ctrl.ps2_dat_mux)
                    2'b00:   odreg <= 1'b1;
                    2'b01:   odreg <= 1'b0;
                    2'b10:   odreg <= shreg[0];
                    default: odreg <= pbit;
                endcase
            end
            if (ctrl.idreg_clk_en) idreg <= shreg;
        end
    end

    always_comb begin
        status                 = '0;
        status.ps2_clk_negedge = clk_d2 & ~clk_d1;
        status.ps2_dat         = dat_d1;
        status.dbits           = (bitcnt >= 4'd1) && (bitcnt <= 4'd8);
        status.bitcnt_9        = (bitcnt == 4'd9);
        status.bitcnt_10       = (bitcnt == 4'd10);
        status.perr            = (dat_d1 != pbit);
        status.tim_tc          = tim_act_q && (tim == lim(tc_sel_q));
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit         is_rx;
        bit         err;
        bit         perr;
        bit         ferr;
        bit         toerr;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   ev_count = 0;
    int   evt_cyc  = 0;

    always @(negedge clk) begin
        if (rx_valid || tx_done) begin
            ev_count++;
            evt_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("unexpected_event", 32'({rx_valid, tx_done}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("event_is_rx", 32'(rx_valid), 32'(e.is_rx));
                check("event_is_tx", 32'(tx_done), 32'(!e.is_rx));
                if (e.is_rx) begin
                    check("rx_perr", 32'(rx_perr), 32'(e.perr));
                    check("rx_ferr", 32'(rx_ferr), 32'(e.ferr));
                    check("rx_toerr", 32'(rx_toerr), 32'(e.toerr));
                    check("rx_data", 32'(idreg), 32'(e.data));
                end else begin
                    check("tx_err", 32'(tx_err), 32'(e.err));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_fall = 0;

    task automatic push_rx(input bit perr, input bit ferr, input bit toerr, input logic [7:0] d);
        exp_t x;
        x.is_rx = 1'b1; x.err = 1'b0; x.perr = perr; x.ferr = ferr; x.toerr = toerr; x.data = d;
        sb_q.push_back(x);
    endtask

    task automatic push_tx(input bit err);
        exp_t x;
        x.is_rx = 1'b0; x.err = err; x.perr = 1'b0; x.ferr = 1'b0; x.toerr = 1'b0; x.data = 8'h00;
        sb_q.push_back(x);
    endtask

    // Device frame: bits[0] is the start bit, sent LSB first, nbits clock pulses
    task automatic dev_send(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            dev_dat = bits[i];
            repeat (5) @(negedge clk);
            dev_clk   = 1'b0;
            last_fall = cyc;
            repeat (10) @(negedge clk);
            dev_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic host_req(input logic [7:0] d);
        @(negedge clk);
        check("tx_ready_idle", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_accept_busy", 32'(busy), 32'd1);
    endtask

    // Count clock-inhibit cycles; returns with the controller in request-to-send
    task automatic wait_rts(output int n);
        n = 0;
        while (ps2_clk_od == 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("inh_len_ge_100us", 32'(n >= 20), 32'd1);
        check("inh_len_le_105us", 32'(n <= 22), 32'd1);
        check("rts_start_low", 32'(pad_dat), 32'd0);
    endtask

    task automatic do_tx(input logic [7:0] d, input logic [9:0] exp_bits);
        int         n;
        logic [9:0] got;
        got = '0;
        push_tx(1'b0);
        host_req(d);
        wait_rts(n);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) dev_dat = 1'b0;  // acknowledge
            repeat (4) @(negedge clk);
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (i < 10) got[i] = pad_dat;
            dev_clk = 1'b1;
            repeat (6) @(negedge clk);
        end
        dev_dat = 1'b1;
        check("tx_line_bits", 32'(got), 32'(exp_bits));
        wait_drain("tx_ack_done", 100);
        check("tx_clk_released", 32'(ps2_clk_od), 32'd1);
        check("tx_dat_released", 32'(pad_dat), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ctrl_t c, exp_idle;
        int    n, rts_start, ev_before;

        rst_n = 1'b0; tx_valid = 1'b0; dev_clk = 1'b1; dev_dat = 1'b1; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset / IDLE values
        check("rst_clk_od", 32'(ps2_clk_od), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({tx_done, tx_err, rx_valid, rx_perr, rx_ferr, rx_toerr}), 32'd0);
        exp_idle = '0;
        exp_idle.odreg_clk_en = 1'b1;
        exp_idle.tim_clear    = 1'b1;
        exp_idle.bitcnt_clear = 1'b1;
        c = ctrl;
        c.shreg_shift_load_n = 1'b0;  // select, not an enable
        c.tc_mux             = 2'b00; // select, not an enable
        check("idle_ctrl", 32'(c), 32'(exp_idle));

        // 0xA5, odd parity 1, stop 1: clean
        push_rx(1'b0, 1'b0, 1'b0, 8'hA5);
        dev_send({1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        wait_drain("rx_ok_done", 100);

        // 0xA5 with parity 0: parity error
        push_rx(1'b1, 1'b0, 1'b0, 8'hA5);
        dev_send({1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        wait_drain("rx_perr_done", 100);

        // 0x5A, parity 1, stop bit 0: framing error
        push_rx(1'b0, 1'b1, 1'b0, 8'h5A);
        dev_send({1'b0, 1'b1, 8'h5A, 1'b0}, 11);
        wait_drain("rx_ferr_done", 100);

        // 0x3C, clock stops after start + 4 data bits: watchdog, data unchanged
        push_rx(1'b0, 1'b0, 1'b1, 8'h5A);
        dev_send({1'b1, 1'b1, 8'h3C, 1'b0}, 5);
        wait_drain("rx_toerr_done", 100);
        check("rx_to_delay_min", 32'((evt_cyc - last_fall) >= 30), 32'd1);
        check("rx_to_delay_max", 32'((evt_cyc - last_fall) <= 36), 32'd1);
        check("rx_to_idle", 32'(busy), 32'd0);

        // Transmit 0xFF (parity 1) and 0x34 (parity 0), both acknowledged
        do_tx(8'hFF, {1'b1, 1'b1, 8'hFF});
        do_tx(8'h34, {1'b1, 1'b0, 8'h34});

        // Transmit with no device response: 15 ms watchdog
        push_tx(1'b1);
        host_req(8'h12);
        wait_rts(n);
        rts_start = cyc;
        wait_drain("tx_to_done", 400);
        check("tx_to_delay_min", 32'((evt_cyc - rts_start) >= 200), 32'd1);
        check("tx_to_delay_max", 32'((evt_cyc - rts_start) <= 206), 32'd1);
        check("tx_to_clk_released", 32'(ps2_clk_od), 32'd1);
        check("tx_to_dat_released", 32'(pad_dat), 32'd1);

        // Reset during clock inhibit
        ev_before = ev_count;
        host_req(8'h77);
        repeat (5) @(negedge clk);
        check("inh_clk_low", 32'(ps2_clk_od), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_clk_od", 32'(ps2_clk_od), 32'd1);
        check("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx_ready_after", 32'(tx_ready), 32'd1);
        repeat (300) @(negedge clk);
        check("rst_no_tx_done", 32'(ev_count), 32'(ev_before));
        check("rst_stays_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
